// File: rtl/uart_fizzbuzz_if.sv
// uart_fizzbuzz_if: serial lines and status flags of the FizzBuzz UART engine
interface uart_fizzbuzz_if;
  logic rx_phy;
  logic tx_phy;
  logic rx_busy;
  logic tx_busy;
  logic busy;
  logic cmd_drop;
  modport master (output rx_phy, input tx_phy, rx_busy, tx_busy, busy, cmd_drop);
  modport slave (input rx_phy, output tx_phy, rx_busy, tx_busy, busy, cmd_drop);
endinterface

// File: rtl/uart_fizzbuzz.sv
// uart_fizzbuzz: UART command-driven FizzBuzz engine with BCD counter; define FB_CRLF_EN to append CR LF to every response
module uart_rx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  rx_state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic last;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = state != R_IDLE;
  // Synchronise the line, then sample each bit near its middle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      state <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
      valid <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      valid <= 1'b0;
      case (state)
        R_IDLE: if (!sync[1]) begin
          state <= R_START;
          cnt <= '0;
        end
        R_START: if (cnt == CW'((CLKS_PER_BIT - 1) / 2)) begin
          state <= sync[1] ? R_IDLE : R_DATA;
          cnt <= '0;
          bit_idx <= '0;
        end else cnt <= cnt + CW'(1);
        R_DATA: if (last) begin
          cnt <= '0;
          data <= {sync[1], data[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= R_STOP;
        end else cnt <= cnt + CW'(1);
        R_STOP: if (last) begin
          valid <= sync[1];
          state <= R_IDLE;
        end else cnt <= cnt + CW'(1);
      endcase
    end
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  logic [8:0] sh;
  logic [3:0] n;
  logic [CW-1:0] cnt;
  // Start bit on accept, then 8 data bits LSB first and one stop bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx <= 1'b1;
      busy <= 1'b0;
      sh <= '1;
      n <= '0;
      cnt <= '0;
    end else if (!busy) begin
      if (valid) begin
        sh <= {1'b1, data};
        tx <= 1'b0;
        busy <= 1'b1;
        cnt <= '0;
        n <= '0;
      end
    end else if (cnt != CW'(CLKS_PER_BIT - 1)) cnt <= cnt + CW'(1);
    else begin
      cnt <= '0;
      n <= n + 4'd1;
      tx <= sh[0];
      sh <= {1'b1, sh[8:1]};
      if (n == 4'd9) begin
        busy <= 1'b0;
        tx <= 1'b1;
      end
    end
endmodule

module uart_fizzbuzz #(
  parameter int CLKS_PER_BIT = 2,
  parameter int CNT_MAX = 100,
  parameter int FIZZ_DIV = 3,
  parameter int BUZZ_DIV = 5
) (
  input logic clk,
  input logic rst,
  uart_fizzbuzz_if.slave bus
);
  function automatic int ndig(input int v);
    int d;
    d = 1;
    for (int x = v; x >= 10; x = x / 10) d++;
    return d;
  endfunction
  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  localparam int DIGITS = ndig(CNT_MAX);
  localparam int SW = DIGITS > 8 ? DIGITS : 8;
`ifdef FB_CRLF_EN
  localparam int BL = SW + 2;
`else
  localparam int BL = SW;
`endif
  localparam int LW = $clog2(BL + 1);
  localparam int FW = $clog2(FIZZ_DIV);
  localparam int BW = $clog2(BUZZ_DIV);
  localparam logic [63:0] MAX_BCD = to_bcd(CNT_MAX);
  localparam logic [63:0] FB = "FizzBuzz";
  typedef enum logic [2:0] {IDLE, UPDATE, LOAD, SEND, GAP} state_t;
  state_t state;
  logic [7:0] rx_data, tx_data, cmd;
  logic rx_valid, tx_valid, tx_busy, busy, cmd_drop, seen, is_cmd, at_max, carry, lead;
  logic [DIGITS-1:0][3:0] cnt, inc;
  logic [FW-1:0] res_f;
  logic [BW-1:0] res_b;
  logic [8*BL-1:0] str, bld, aln;
  logic [LW-1:0] rem, bld_len;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(rst), .rx(bus.rx_phy), .data(rx_data), .valid(rx_valid), .busy(bus.rx_busy)
  );
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst(rst), .data(tx_data), .valid(tx_valid), .tx(bus.tx_phy), .busy(tx_busy)
  );
  assign bus.tx_busy = tx_busy;
  assign bus.busy = busy;
  assign bus.cmd_drop = cmd_drop;
  assign is_cmd = rx_data == "r" || rx_data == "n" || rx_data == "p";
  assign at_max = cnt == MAX_BCD[4*DIGITS-1:0];
  assign aln = bld << (8 * (BL - int'(bld_len)));
  // Decimal increment rippling the carry through every digit
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      inc[i] = carry ? (cnt[i] == 4'd9 ? 4'd0 : cnt[i] + 4'd1) : cnt[i];
      carry = carry && cnt[i] == 4'd9;
    end
  end
  // Response text assembled right-aligned, first character highest
  always_comb begin
    bld = '0;
    bld_len = '0;
    lead = 1'b0;
    if (cnt == '0) begin
      bld[7:0] = "0";
      bld_len = LW'(1);
    end else if (res_f == '0 && res_b == '0) begin
      bld[63:0] = FB;
      bld_len = LW'(8);
    end else if (res_f == '0) begin
      bld[31:0] = FB[63:32];
      bld_len = LW'(4);
    end else if (res_b == '0) begin
      bld[31:0] = FB[31:0];
      bld_len = LW'(4);
    end else
      for (int i = DIGITS - 1; i >= 0; i--)
        if (lead || cnt[i] != 4'd0) begin
          lead = 1'b1;
          bld = {bld[8*BL-9:0], 4'h3, cnt[i]};
          bld_len = bld_len + LW'(1);
        end
`ifdef FB_CRLF_EN
    bld = {bld[8*BL-17:0], 16'h0d0a};
    bld_len = bld_len + LW'(2);
`endif
  end
  // Command FSM: update count, build the string, stream it byte by byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      res_f <= '0;
      res_b <= '0;
      cmd <= '0;
      str <= '0;
      rem <= '0;
      seen <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      busy <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      cmd_drop <= rx_valid && is_cmd && state != IDLE;
      case (state)
        IDLE: if (rx_valid && is_cmd) begin
          cmd <= rx_data;
          busy <= 1'b1;
          state <= UPDATE;
        end
        UPDATE: begin
          if (cmd == "r") begin
            cnt <= (4 * DIGITS)'(1);
            res_f <= FW'(1 % FIZZ_DIV);
            res_b <= BW'(1 % BUZZ_DIV);
          end else if (cmd == "n") begin
            cnt <= at_max ? '0 : inc;
            res_f <= at_max || res_f == FW'(FIZZ_DIV - 1) ? '0 : res_f + FW'(1);
            res_b <= at_max || res_b == BW'(BUZZ_DIV - 1) ? '0 : res_b + BW'(1);
          end
          state <= LOAD;
        end
        LOAD: begin
          str <= aln;
          rem <= bld_len;
          seen <= 1'b0;
          state <= SEND;
          if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data <= aln[8*BL-1-:8];
          end
        end
        SEND: if (tx_valid) begin
          tx_valid <= 1'b0;
          seen <= 1'b0;
          state <= GAP;
        end else if (!tx_busy) begin
          tx_valid <= 1'b1;
          tx_data <= str[8*BL-1-:8];
        end
        GAP: if (tx_busy) seen <= 1'b1;
        else if (seen) begin
          if (rem == LW'(1)) begin
            busy <= 1'b0;
            state <= IDLE;
          end else begin
            rem <= rem - LW'(1);
            str <= str << 8;
            tx_valid <= 1'b1;
            tx_data <= str[8*BL-9-:8];
            seen <= 1'b0;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
